cond_exec: RTL and testbench

COND_EXEC -- requirements
Module: cond_exec

---
 rtl/arm_pkg.sv | 38 +++
 rtl/cond_check.sv | 40 ++++
 rtl/cond_exec.sv | 109 ++++++++++
 tb/tb_cond_exec.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM-style conditional-execute stage:
// condition codes and flag bit positions.
package arm_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_t;

  localparam int N = 3;
  localparam int Z = 2;
  localparam int C = 1;
  localparam int V = 0;

  typedef struct packed {
    logic        valid;
    logic        pcsrc;
    logic        regw;
    logic        memw;
    logic [31:0] result;
    logic [3:0]  wa;
  } m_reg_t;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of an ARM condition field
// against a {N,Z,C,V} flag vector.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[N];
  assign z = flags[Z];
  assign c = flags[C];
  assign v = flags[V];

  always_comb begin
    pass = 1'b0;
    unique case (cond_t'(cond))
      EQ: pass = z;
      NE: pass = ~z;
      CS: pass = c;
      CC: pass = ~c;
      MI: pass = n;
      PL: pass = ~n;
      VS: pass = v;
      VC: pass = ~v;
      HI: pass = c & ~z;
      LS: pass = ~c | z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = ~z & (n == v);
      LE: pass = z | (n != v);
      AL: pass = 1'b1;
      NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec.sv
// Execute-stage conditional logic: architectural flags,
// E->M control register and retired/squashed counters.
module cond_exec
  import arm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             valid_e,
  input  logic [3:0]       cond_e,
  input  logic [1:0]       flagw_e,
  input  logic             pcs_e,
  input  logic             regw_e,
  input  logic             memw_e,
  input  logic             nowrite_e,
  input  logic [3:0]       alu_flags,
  input  logic [31:0]      alu_result_e,
  input  logic [3:0]       wa_e,
  output logic             carry_o,
  output logic [3:0]       flags_o,
  output logic             condex_o,
  output logic             valid_m,
  output logic             pcsrc_m,
  output logic             regw_m,
  output logic             memw_m,
  output logic [31:0]      alu_result_m,
  output logic [3:0]       wa_m,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] squashed_cnt
);

  logic       accepted;
  logic       exec;
  logic [3:0] flags_q;
  m_reg_t     m_q;
  m_reg_t     m_d;

  // Condition sees only committed flags, never the live ALU flags
  cond_check u_cond_check (
    .cond  (cond_e),
    .flags (flags_q),
    .pass  (condex_o)
  );

  assign accepted = en & valid_e & ~flush;
  assign exec     = accepted & condex_o;

  always_comb begin
    m_d        = '0;
    m_d.valid  = valid_e & ~flush;
    m_d.pcsrc  = exec & pcs_e;
    m_d.regw   = exec & regw_e & ~nowrite_e;
    m_d.memw   = exec & memw_e;
    m_d.result = alu_result_e;
    m_d.wa     = wa_e;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
    end else if (exec) begin
      if (flagw_e[1]) begin
        flags_q[N] <= alu_flags[N];
        flags_q[Z] <= alu_flags[Z];
      end
      if (flagw_e[0]) begin
        flags_q[C] <= alu_flags[C];
        flags_q[V] <= alu_flags[V];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q <= '0;
    end else if (en) begin
      m_q <= m_d;
    end
  end

  // Counters stick at all-ones rather than wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt  <= '0;
      squashed_cnt <= '0;
    end else if (accepted) begin
      if (condex_o) begin
        if (retired_cnt != '1)
          retired_cnt <= retired_cnt + 1'b1;
      end else begin
        if (squashed_cnt != '1)
          squashed_cnt <= squashed_cnt + 1'b1;
      end
    end
  end

  assign flags_o      = flags_q;
  assign carry_o      = flags_q[C];
  assign valid_m      = m_q.valid;
  assign pcsrc_m      = m_q.pcsrc;
  assign regw_m       = m_q.regw;
  assign memw_m       = m_q.memw;
  assign alu_result_m = m_q.result;
  assign wa_m         = m_q.wa;

endmodule

// File: tb/tb_cond_exec.sv
// Directed testbench for cond_exec with hand-computed
// expectations; counters run at CNT_W=4.
module tb_cond_exec;
  import arm_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          flush;
  logic          valid_e;
  logic [3:0]    cond_e;
  logic [1:0]    flagw_e;
  logic          pcs_e;
  logic          regw_e;
  logic          memw_e;
  logic          nowrite_e;
  logic [3:0]    alu_flags;
  logic [31:0]   alu_result_e;
  logic [3:0]    wa_e;
  logic          carry_o;
  logic [3:0]    flags_o;
  logic          condex_o;
  logic          valid_m;
  logic          pcsrc_m;
  logic          regw_m;
  logic          memw_m;
  logic [31:0]   alu_result_m;
  logic [3:0]    wa_m;
  logic [CW-1:0] retired_cnt;
  logic [CW-1:0] squashed_cnt;

  int n_chk = 0;
  int n_fail = 0;

  cond_exec #(.CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .flush        (flush),
    .valid_e      (valid_e),
    .cond_e       (cond_e),
    .flagw_e      (flagw_e),
    .pcs_e        (pcs_e),
    .regw_e       (regw_e),
    .memw_e       (memw_e),
    .nowrite_e    (nowrite_e),
    .alu_flags    (alu_flags),
    .alu_result_e (alu_result_e),
    .wa_e         (wa_e),
    .carry_o      (carry_o),
    .flags_o      (flags_o),
    .condex_o     (condex_o),
    .valid_m      (valid_m),
    .pcsrc_m      (pcsrc_m),
    .regw_m       (regw_m),
    .memw_m       (memw_m),
    .alu_result_m (alu_result_m),
    .wa_m         (wa_m),
    .retired_cnt  (retired_cnt),
    .squashed_cnt (squashed_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input cond_t c, input logic [1:0] fw,
                       input logic [3:0] af, input logic rw,
                       input logic mw);
    en        = 1'b1;
    flush     = 1'b0;
    valid_e   = 1'b1;
    cond_e    = c;
    flagw_e   = fw;
    alu_flags = af;
    regw_e    = rw;
    memw_e    = mw;
    pcs_e     = 1'b0;
    nowrite_e = 1'b0;
  endtask

  task automatic cnts(input string tag, input int r, input int s);
    check({tag, " retired"}, 32'(retired_cnt), r);
    check({tag, " squashed"}, 32'(squashed_cnt), s);
  endtask

  task automatic all_zero(input string tag);
    check({tag, " flags"}, 32'(flags_o), 0);
    check({tag, " carry"}, 32'(carry_o), 0);
    check({tag, " valid_m"}, 32'(valid_m), 0);
    check({tag, " pcsrc_m"}, 32'(pcsrc_m), 0);
    check({tag, " regw_m"}, 32'(regw_m), 0);
    check({tag, " memw_m"}, 32'(memw_m), 0);
    check({tag, " result_m"}, alu_result_m, 0);
    check({tag, " wa_m"}, 32'(wa_m), 0);
    cnts(tag, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0; flush = 1'b0; valid_e = 1'b0;
    cond_e = 4'hE; flagw_e = 2'b00; pcs_e = 1'b0;
    regw_e = 1'b0; memw_e = 1'b0; nowrite_e = 1'b0;
    alu_flags = 4'h0; alu_result_e = 32'h1234; wa_e = 4'd5;
    #12;
    all_zero("reset");
    reset = 1'b0;

    // CMP then BEQ back to back
    instr(AL, 2'b11, 4'b0100, 1'b0, 1'b0);
    check("cmp condex", 32'(condex_o), 1);
    tick();
    check("cmp flags", 32'(flags_o), 4'b0100);
    instr(EQ, 2'b00, 4'b0000, 1'b1, 1'b0);
    check("beq condex", 32'(condex_o), 1);
    tick();
    check("beq regw_m", 32'(regw_m), 1);
    check("beq valid_m", 32'(valid_m), 1);
    check("beq wa_m", 32'(wa_m), 5);
    check("beq result_m", alu_result_m, 32'h1234);
    check("beq flags", 32'(flags_o), 4'b0100);
    cnts("beq", 2, 0);

    instr(EQ, 2'b00, 4'b0000, 1'b1, 1'b0);
    pcs_e = 1'b1;
    nowrite_e = 1'b1;
    tick();
    check("nowrite pcsrc_m", 32'(pcsrc_m), 1);
    check("nowrite regw_m", 32'(regw_m), 0);

    // Partial flag writes
    instr(AL, 2'b01, 4'b1111, 1'b0, 1'b0);
    tick();
    check("fw01 flags", 32'(flags_o), 4'b0111);
    check("fw01 carry", 32'(carry_o), 1);
    instr(AL, 2'b10, 4'b1000, 1'b0, 1'b0);
    tick();
    check("fw10 flags", 32'(flags_o), 4'b1011);
    cnts("fw", 5, 0);

    // flags N=1 Z=0 C=1 V=1
    cond_e = GE; #1 check("GE", 32'(condex_o), 1);
    cond_e = LT; #1 check("LT", 32'(condex_o), 0);
    cond_e = GT; #1 check("GT", 32'(condex_o), 1);
    cond_e = LE; #1 check("LE", 32'(condex_o), 0);
    cond_e = HI; #1 check("HI", 32'(condex_o), 1);
    cond_e = LS; #1 check("LS", 32'(condex_o), 0);
    cond_e = VC; #1 check("VC", 32'(condex_o), 0);
    cond_e = PL; #1 check("PL", 32'(condex_o), 0);

    valid_e = 1'b0;
    reset = 1'b1;
    #1;
    all_zero("pulse");
    reset = 1'b0;
    tick();

    // NE writes flags, MI then sees them
    instr(NE, 2'b11, 4'b1000, 1'b0, 1'b0);
    check("ne condex", 32'(condex_o), 1);
    tick();
    check("ne flags", 32'(flags_o), 4'b1000);
    instr(MI, 2'b00, 4'b0000, 1'b0, 1'b0);
    check("mi condex", 32'(condex_o), 1);
    tick();
    cnts("mi", 2, 0);

    instr(AL, 2'b11, 4'b0100, 1'b0, 1'b0);
    tick();
    instr(NE, 2'b11, 4'b1111, 1'b0, 1'b1);
    check("sq condex", 32'(condex_o), 0);
    tick();
    check("sq memw_m", 32'(memw_m), 0);
    check("sq valid_m", 32'(valid_m), 1);
    check("sq flags", 32'(flags_o), 4'b0100);
    cnts("sq", 3, 1);

    // Stalled stage ignores flush and valid
    instr(AL, 2'b11, 4'b0000, 1'b1, 1'b0);
    en = 1'b0;
    flush = 1'b1;
    wa_e = 4'd9;
    alu_result_e = 32'hBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold valid_m", 32'(valid_m), 1);
      check("hold wa_m", 32'(wa_m), 5);
      check("hold flags", 32'(flags_o), 4'b0100);
      cnts("hold", 3, 1);
    end
    en = 1'b1;
    tick();
    check("flush valid_m", 32'(valid_m), 0);
    check("flush regw_m", 32'(regw_m), 0);
    check("flush wa_m", 32'(wa_m), 9);
    check("flush result_m", alu_result_m, 32'hBEEF);
    check("flush flags", 32'(flags_o), 4'b0100);
    cnts("flush", 3, 1);

    // Saturation at CNT_W=4
    instr(AL, 2'b00, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick();
    check("sat reach", 32'(retired_cnt), 15);
    tick();
    check("sat hold", 32'(retired_cnt), 15);
    check("sat regw_m", 32'(regw_m), 1);
    cond_e = NV;
    #1 check("NV condex", 32'(condex_o), 0);
    tick();
    cnts("nv", 15, 2);
    check("nv regw_m", 32'(regw_m), 0);

    // Reset between edges clears everything immediately
    instr(EQ, 2'b11, 4'b1111, 1'b1, 1'b0);
    check("pre-rst condex", 32'(condex_o), 1);
    #2 reset = 1'b1;
    #1;
    all_zero("async");
    check("async condex", 32'(condex_o), 0);
    tick();
    all_zero("held");
    reset = 1'b0;
    instr(AL, 2'b11, 4'b0010, 1'b0, 1'b0);
    tick();
    check("post flags", 32'(flags_o), 4'b0010);
    check("post carry", 32'(carry_o), 1);
    cnts("post", 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
